// File: rtl/pipelined_shifter_pkg.sv
// shifter: shared op encodings and helpers for the shift/rotate pipeline
package shifter;
  typedef enum logic [2:0] {SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4} op_t;
  function automatic logic is_legal(op_t op);
    return op inside {SLL, SRL, SRA, ROL, ROR};
  endfunction
endpackage

// File: rtl/pipelined_shifter_stage.sv
// pipelined_shifter_stage: applies the amount bits owned by stage S; the last stage sign-extends word results
module pipelined_shifter_stage
  import shifter::*;
#(
  parameter int XLEN = 64,
  parameter int STAGES = 2,
  parameter int S = 0,
  parameter int LAST = 0,
  localparam int SW = $clog2(XLEN)
) (
  input  op_t             op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [SW-1:0]   n_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] r, sra;
  logic signed [31:0] lo;
  always_comb begin
    r = data_i;
    sra = '0;
    for (int j = 0; j < SW; j++)
      if (j * STAGES / SW == S && n_i[j] && !(word_i && j >= 5)) begin
        sra = $signed(r) >>> (1 << j);
        r = op_i == SLL ? r << (1 << j) :
            op_i == SRL ? r >> (1 << j) :
            op_i == SRA ? sra :
            op_i == ROL ? (r << (1 << j)) | (r >> (XLEN - (1 << j))) :
            op_i == ROR ? (r >> (1 << j)) | (r << (XLEN - (1 << j))) : '0;
      end
    lo = r[31:0];
    data_o = LAST != 0 && word_i ? XLEN'(lo) : r;
  end
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: STAGES-deep shift/rotate pipeline with valid/ready, tag, flush; in_ready depends combinationally on out_ready
module pipelined_shifter
  import shifter::*;
#(
  parameter int XLEN = 64,
  parameter int STAGES = 2,
  parameter int TAG_W = 5,
  parameter int WORD_OPS = 1,
  localparam int SW = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              in_op,
  input  logic             in_is_word_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [SW-1:0]    in_n,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam bit WORD_EN = WORD_OPS != 0 && XLEN == 64;
  typedef struct packed {
    op_t              op;
    logic             word;
    logic [XLEN-1:0]  data;
    logic [SW-1:0]    n;
    logic [TAG_W-1:0] tag;
  } pl_t;
  pl_t src [STAGES];
  pl_t pl_q [STAGES];
  logic [XLEN-1:0] res [STAGES];
  logic [STAGES-1:0] v_q, adv, vin;
  logic is_word;
  logic signed [31:0] a_lo;
  logic [XLEN-1:0] a_sx, d0;
  always_comb begin
    is_word = WORD_EN && in_is_word_op;
    a_lo = in_a[31:0];
    a_sx = XLEN'(a_lo);
    d0 = !is_legal(in_op) ? '0 :
         !is_word ? in_a :
         in_op == SRL ? XLEN'(in_a[31:0]) :
         in_op inside {ROL, ROR} ? {(XLEN / 32){in_a[31:0]}} : a_sx;
    src[0] = '{op: in_op, word: is_word, data: d0, n: in_n, tag: in_tag};
    for (int s = 1; s < STAGES; s++) src[s] = pl_q[s-1];
  end
  always_comb begin
    adv = '0;
    vin = '0;
    adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int s = STAGES - 2; s >= 0; s--) adv[s] = !v_q[s] || adv[s+1];
    vin[0] = in_valid && adv[0] && !flush;
    for (int s = 1; s < STAGES; s++) vin[s] = v_q[s-1];
  end
  assign in_ready = adv[0] && !flush;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    pipelined_shifter_stage #(
      .XLEN(XLEN), .STAGES(STAGES), .S(s), .LAST(s == STAGES - 1)
    ) u_stage (
      .op_i(src[s].op), .word_i(src[s].word), .data_i(src[s].data), .n_i(src[s].n), .data_o(res[s])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) pl_q[s] <= '0;
    end else
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= !flush && (adv[s] ? vin[s] : v_q[s]);
        if (adv[s]) pl_q[s] <= '{op: src[s].op, word: src[s].word, data: res[s], n: src[s].n, tag: src[s].tag};
      end
  assign out_valid = v_q[STAGES-1];
  assign out_result = pl_q[STAGES-1].data;
  assign out_tag = pl_q[STAGES-1].tag;
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: scoreboard bench driving STAGES=1,2,6 instances with shared stimulus
module tb_pipelined_shifter;
  import shifter::*;
  localparam int ST [3] = '{1, 2, 6};
  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          cyc;
    bit          tight;
  } exp_t;
  logic clk = 0, reset, flush, in_valid, in_is_word_op;
  op_t in_op;
  logic [63:0] in_a, exp_now;
  logic [5:0] in_n;
  logic [4:0] in_tag;
  logic [2:0] ird, ovd, ordy;
  logic [63:0] ores [3];
  logic [4:0] otag [3];
  exp_t sb [3][$];
  bit hold [3];
  logic [63:0] held [3];
  bit tight;
  int cyc = 0, n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  pipelined_shifter #(.XLEN(64), .STAGES(1), .TAG_W(5), .WORD_OPS(1)) u_s1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ird[0]), .in_op(in_op),
    .in_is_word_op(in_is_word_op), .in_a(in_a), .in_n(in_n), .in_tag(in_tag), .out_valid(ovd[0]),
    .out_ready(ordy[0]), .out_result(ores[0]), .out_tag(otag[0]));
  pipelined_shifter #(.XLEN(64), .STAGES(2), .TAG_W(5), .WORD_OPS(1)) u_s2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ird[1]), .in_op(in_op),
    .in_is_word_op(in_is_word_op), .in_a(in_a), .in_n(in_n), .in_tag(in_tag), .out_valid(ovd[1]),
    .out_ready(ordy[1]), .out_result(ores[1]), .out_tag(otag[1]));
  pipelined_shifter #(.XLEN(64), .STAGES(6), .TAG_W(5), .WORD_OPS(1)) u_s6 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ird[2]), .in_op(in_op),
    .in_is_word_op(in_is_word_op), .in_a(in_a), .in_n(in_n), .in_tag(in_tag), .out_valid(ovd[2]),
    .out_ready(ordy[2]), .out_result(ores[2]), .out_tag(otag[2]));
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] model(logic [2:0] op, logic w, logic [63:0] a, logic [5:0] n);
    logic [31:0] x, y;
    logic [63:0] z;
    int m;
    if (op > 3'd4) return 64'd0;
    if (w) begin
      x = a[31:0];
      m = int'(n[4:0]);
      y = $signed(x) >>> m;
      case (op)
        3'd0: y = x << m;
        3'd1: y = x >> m;
        3'd2: ;
        3'd3: y = m == 0 ? x : (x << m) | (x >> (32 - m));
        default: y = m == 0 ? x : (x >> m) | (x << (32 - m));
      endcase
      return {{32{y[31]}}, y};
    end
    m = int'(n);
    z = $signed(a) >>> m;
    case (op)
      3'd0: z = a << m;
      3'd1: z = a >> m;
      3'd2: ;
      3'd3: z = m == 0 ? a : (a << m) | (a >> (64 - m));
      default: z = m == 0 ? a : (a >> m) | (a << (64 - m));
    endcase
    return z;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (hold[k]) begin
        chk("hold_valid", ovd[k], 1);
        chk("hold_result", ores[k], held[k]);
      end
      if (reset) begin
        sb[k].delete();
        hold[k] = 0;
        continue;
      end
      if (ovd[k] && ordy[k]) begin
        if (sb[k].size() == 0) chk("spurious_out", ovd[k], 0);
        else begin
          e = sb[k].pop_front();
          chk("result", ores[k], e.res);
          chk("tag", otag[k], e.tag);
          if (e.tight && tight) chk("latency", cyc - e.cyc, ST[k]);
        end
      end
      hold[k] = ovd[k] && !ordy[k] && !flush;
      held[k] = ores[k];
      if (flush) sb[k].delete();
      else if (in_valid && ird[k]) sb[k].push_back('{exp_now, in_tag, cyc, tight});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(op_t op, logic w, logic [63:0] a, logic [5:0] n, logic [4:0] t, logic [63:0] e);
    in_valid = 1;
    in_op = op;
    in_is_word_op = w;
    in_a = a;
    in_n = n;
    in_tag = t;
    exp_now = e;
    step();
  endtask
  task automatic rnd_in();
    in_op = op_t'(3'($urandom_range(0, 7)));
    in_is_word_op = 1'($urandom);
    in_a = {$urandom, $urandom};
    in_n = 6'($urandom);
    in_tag = 5'($urandom);
    exp_now = model(in_op, in_is_word_op, in_a, in_n);
  endtask
  task automatic drain(string tag);
    flush = 0;
    reset = 0;
    in_valid = 0;
    ordy = 3'b111;
    repeat (10) step();
    for (int k = 0; k < 3; k++) chk(tag, sb[k].size(), 0);
  endtask
  initial begin
    reset = 1;
    flush = 0;
    in_valid = 0;
    in_op = SLL;
    in_is_word_op = 0;
    in_a = 0;
    in_n = 0;
    in_tag = 0;
    exp_now = 0;
    ordy = 3'b111;
    tight = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", ovd[k], 0);
      chk("rst_result", ores[k], 0);
      chk("rst_tag", otag[k], 0);
      chk("rst_ready", ird[k], 1);
    end
    step();
    send(SRA, 0, 64'h8000_0000_0000_0001, 6'd1, 5'd1, 64'hC000_0000_0000_0000);
    send(ROR, 0, 64'h0000_0000_0000_00F1, 6'd4, 5'd2, 64'h1000_0000_0000_000F);
    send(ROL, 0, 64'hDEAD_BEEF_0123_4567, 6'd0, 5'd3, 64'hDEAD_BEEF_0123_4567);
    send(SRL, 1, 64'hFFFF_FFFF_8000_0000, 6'd33, 5'd4, 64'h0000_0000_4000_0000);
    send(SLL, 1, 64'h0000_0000_0000_0001, 6'd31, 5'd5, 64'hFFFF_FFFF_8000_0000);
    send(op_t'(3'd6), 0, 64'h0000_0000_0000_0123, 6'd5, 5'd6, 64'h0);
    send(ROR, 1, 64'h0000_0000_0000_0001, 6'd1, 5'd7, 64'hFFFF_FFFF_8000_0000);
    send(SLL, 0, 64'h0000_0000_0000_0003, 6'd63, 5'd8, 64'h8000_0000_0000_0000);
    send(SRA, 1, 64'h0000_0000_8000_0000, 6'd4, 5'd9, 64'hFFFF_FFFF_F800_0000);
    for (int i = 0; i < 10; i++) begin
      rnd_in();
      step();
    end
    drain("drain_directed");
    tight = 0;
    ordy = 3'b000;
    in_valid = 1;
    repeat (5) begin
      rnd_in();
      step();
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready", ird[k], ST[k] > 5);
      chk("hold_occupancy", sb[k].size(), ST[k] < 5 ? ST[k] : 5);
    end
    in_valid = 0;
    ordy = 3'b111;
    step();
    drain("drain_backpressure");
    ordy = 3'b000;
    in_valid = 1;
    repeat (7) begin
      rnd_in();
      step();
    end
    flush = 1;
    rnd_in();
    #2;
    for (int k = 0; k < 3; k++) chk("flush_ready", ird[k], 0);
    step();
    flush = 0;
    in_valid = 0;
    #2;
    for (int k = 0; k < 3; k++) chk("flush_valid", ovd[k], 0);
    ordy = 3'b111;
    step();
    tight = 1;
    send(SRL, 0, 64'h0000_0000_0000_00F0, 6'd4, 5'd21, 64'h0000_0000_0000_000F);
    drain("drain_post_flush");
    tight = 0;
    for (int i = 0; i < 600; i++) begin
      rnd_in();
      in_valid = $urandom_range(0, 4) != 0;
      for (int k = 0; k < 3; k++) ordy[k] = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 49) == 0;
      reset = i >= 300 && i < 302;
      if (i == 302) begin
        #2;
        for (int k = 0; k < 3; k++) chk("post_reset_valid", ovd[k], 0);
      end
      step();
    end
    drain("drain_random");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
